control_unit: RTL and testbench

- Main-decoder control unit for the pipelined microprocessor; sits in the decode stage.
- Decodes the 6-bit instruction opcode into three packed control bundles, registered once and handed to the ID/EX pipeline register:
  - write-back (WB) bundle
  - memory-access (MEM) bundle
  - calculation/execute (EX) bundle
- Also flags unsupported opcodes and supports a pipeline flush (bubble insertion).

---
 rtl/control_pkg.sv | 17 +
 rtl/control_decode.sv | 27 ++
 rtl/control_unit.sv | 54 +++++
 tb/tb_control_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: opcodes, aluOp encodings and bundle widths shared by the control unit
package control_pkg;
   localparam int OPCODE_WIDTH = 6;
   localparam int WB_W  = 2;
   localparam int MEM_W = 3;
   localparam int EX_W  = 4;
   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h01;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h02;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h03;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h04;
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h05;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC = 2'b11;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode-to-control-bundle table
module control_decode
   import control_pkg::*;
(
   input  logic [OPCODE_WIDTH-1:0] op_code,
   output logic [WB_W-1:0]         wb,
   output logic [MEM_W-1:0]        mem,
   output logic [EX_W-1:0]         ex,
   output logic                    illegal
);
   // table lookup; unknown opcodes become a bubble flagged as illegal
   always_comb begin
      wb      = '0;
      mem     = '0;
      ex      = '0;
      illegal = 1'b0;
      case (op_code)
         OP_RTYPE: begin wb = 2'b10; ex = {1'b1, ALUOP_FUNCT, 1'b0}; end
         OP_LW:    begin wb = 2'b11; mem = 3'b010; ex = {1'b0, ALUOP_ADD, 1'b1}; end
         OP_SW:    begin mem = 3'b001; ex = {1'b0, ALUOP_ADD, 1'b1}; end
         OP_BEQ:   begin mem = 3'b100; ex = {1'b0, ALUOP_SUB, 1'b0}; end
         OP_ADDI:  begin wb = 2'b10; ex = {1'b0, ALUOP_ADD, 1'b1}; end
         OP_ANDI:  begin wb = 2'b10; ex = {1'b0, ALUOP_LOGIC, 1'b1}; end
         default:  illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/control_unit.sv
// control_unit: decode-stage main decoder with registered, flushable control bundles
module control_unit
   import control_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opCode,
   input  logic                    flush,
   output logic [WB_W-1:0]         writeBackControl,
   output logic [MEM_W-1:0]        memAccessControl,
   output logic [EX_W-1:0]         calculationControl,
   output logic                    illegalOp
);
   logic [WB_W-1:0]  dec_wb, wb_d, wb_q;
   logic [MEM_W-1:0] dec_mem, mem_d, mem_q;
   logic [EX_W-1:0]  dec_ex, ex_d, ex_q;
   logic             dec_illegal, illegal_d, illegal_q;

   control_decode u_decode (
      .op_code (opCode),
      .wb      (dec_wb),
      .mem     (dec_mem),
      .ex      (dec_ex),
      .illegal (dec_illegal)
   );

   // flush replaces the decoded bundles with a bubble
   always_comb begin
      wb_d      = flush ? '0 : dec_wb;
      mem_d     = flush ? '0 : dec_mem;
      ex_d      = flush ? '0 : dec_ex;
      illegal_d = flush ? 1'b0 : dec_illegal;
   end

   // output register; reset loads a bubble and overrides everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_q      <= '0;
         mem_q     <= '0;
         ex_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         wb_q      <= wb_d;
         mem_q     <= mem_d;
         ex_q      <= ex_d;
         illegal_q <= illegal_d;
      end
   end

   assign writeBackControl   = wb_q;
   assign memAccessControl   = mem_q;
   assign calculationControl = ex_q;
   assign illegalOp          = illegal_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random checks of the registered control decoder
module tb_control_unit;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op_code;
   logic       flush;
   logic [1:0] wb;
   logic [2:0] mem;
   logic [3:0] ex;
   logic       ill;
   logic [9:0] outs;
   int         n_chk = 0;
   int         n_fail = 0;

   localparam logic [9:0] E_R    = 10'b10_000_1100_0;
   localparam logic [9:0] E_LW   = 10'b11_010_0001_0;
   localparam logic [9:0] E_SW   = 10'b00_001_0001_0;
   localparam logic [9:0] E_BEQ  = 10'b00_100_0010_0;
   localparam logic [9:0] E_ADDI = 10'b10_000_0001_0;
   localparam logic [9:0] E_ANDI = 10'b10_000_0111_0;
   localparam logic [9:0] E_ILL  = 10'b00_000_0000_1;
   localparam logic [9:0] E_NOP  = 10'b00_000_0000_0;

   control_unit dut (
      .clk                (clk),
      .rst                (rst),
      .opCode             (op_code),
      .flush              (flush),
      .writeBackControl   (wb),
      .memAccessControl   (mem),
      .calculationControl (ex),
      .illegalOp          (ill)
   );

   always #5 clk = ~clk;
   assign outs = {wb, mem, ex, ill};

   function automatic logic [9:0] model(input logic [5:0] op);
      case (op)
         6'h00:   return E_R;
         6'h01:   return E_LW;
         6'h02:   return E_SW;
         6'h03:   return E_BEQ;
         6'h04:   return E_ADDI;
         6'h05:   return E_ANDI;
         default: return E_ILL;
      endcase
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [5:0] op, input logic fl, input logic r);
      op_code = op;
      flush   = fl;
      rst     = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] rop;
      rst = 1'b0; flush = 1'b0; op_code = 6'h01;
      step(6'h01, 1'b0, 1'b0);
      step(6'h01, 1'b0, 1'b0);
      check("reset", outs, E_NOP);
      step(6'h01, 1'b0, 1'b1);
      check("lw_after_reset", outs, E_LW);
      step(6'h00, 1'b0, 1'b1); check("sweep_r", outs, E_R);
      step(6'h01, 1'b0, 1'b1); check("sweep_lw", outs, E_LW);
      step(6'h02, 1'b0, 1'b1); check("sweep_sw", outs, E_SW);
      step(6'h03, 1'b0, 1'b1); check("sweep_beq", outs, E_BEQ);
      step(6'h04, 1'b0, 1'b1); check("addi", outs, E_ADDI);
      step(6'h05, 1'b0, 1'b1); check("andi", outs, E_ANDI);
      step(6'h06, 1'b0, 1'b1); check("ill_06", outs, E_ILL);
      step(6'h23, 1'b0, 1'b1); check("ill_23", outs, E_ILL);
      step(6'h3F, 1'b0, 1'b1); check("ill_3f", outs, E_ILL);
      step(6'h00, 1'b0, 1'b1); check("ill_clear", outs, E_R);
      step(6'h01, 1'b1, 1'b1); check("flush_lw", outs, E_NOP);
      step(6'h3F, 1'b1, 1'b1); check("flush_ill", outs, E_NOP);
      step(6'h05, 1'b0, 1'b1); check("pre_rst", outs, E_ANDI);
      step(6'h01, 1'b1, 1'b0); check("rst_and_flush", outs, E_NOP);
      step(6'h01, 1'b0, 1'b0); check("rst_mid", outs, E_NOP);
      step(6'h01, 1'b0, 1'b1); check("unflush_lw", outs, E_LW);
      for (int i = 0; i < 1000; i++) begin
         rop = 6'($urandom_range(0, 63));
         step(rop, 1'b0, 1'b1);
         check("rand_decode", outs, model(rop));
         check("inv_rd_wr", {9'b0, mem[1] & mem[0]}, 10'b0);
         check("inv_m2r", {9'b0, wb[0] & ~mem[1]}, 10'b0);
         check("inv_ill_zero", {9'b0, ill & (|{wb, mem, ex})}, 10'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
